// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch/CALL/RET selector encodings.
package cpu_pkg;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_CALL = 3'b010,
    F3_RET  = 3'b011,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } func3_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push when full overwrites the oldest entry.
module ras_stack #(
  parameter int unsigned XLEN      = 19,
  parameter int unsigned RAS_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [XLEN-1:0]            push_data_i,
  output logic [XLEN-1:0]            top_o,
  output logic [$clog2(RAS_DEPTH):0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [XLEN-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0]   r_sp;     // next slot to write; equals oldest slot when full
  logic [CW-1:0]   r_count;

  // Entry storage carries no reset; entries are only read after being pushed.
  always_ff @(posedge clk) begin
    if (push_i) begin
      r_mem[r_sp] <= push_data_i;
    end
  end

  // Stack pointer and occupancy; pointer wraps so overflow overwrites the oldest entry.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sp    <= '0;
      r_count <= '0;
    end else if (push_i) begin
      r_sp <= r_sp + PW'(1);
      if (r_count != CW'(RAS_DEPTH)) begin
        r_count <= r_count + CW'(1);
      end
    end else if (pop_i && (r_count != '0)) begin
      r_sp    <= r_sp - PW'(1);
      r_count <= r_count - CW'(1);
    end
  end

  assign top_o   = r_mem[r_sp - PW'(1)];
  assign count_o = r_count;
  assign full_o  = (r_count == CW'(RAS_DEPTH));
  assign empty_o = (r_count == '0);

endmodule

// File: rtl/pc_ras_unit.sv
// Program counter with next-PC selection and return-address stack for CALL/RET.
module pc_ras_unit
  import cpu_pkg::*;
#(
  parameter int unsigned     XLEN      = 19,
  parameter int unsigned     RAS_DEPTH = 8,
  parameter logic [XLEN-1:0] RESET_PC  = 19'h00100,
  parameter logic [XLEN-1:0] TRAP_PC   = 19'h00000,
  parameter int unsigned     PC_STEP   = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       stall_i,
  input  logic                       is_b_type_i,
  input  logic [2:0]                 func3_i,
  input  logic                       br_taken_i,
  input  logic                       pc_sel_i,
  input  logic [XLEN-1:0]            target_i,
  input  logic                       err_clr_i,
  output logic [XLEN-1:0]            pc_q,
  output logic [$clog2(RAS_DEPTH):0] ras_count_o,
  output logic                       ras_full_o,
  output logic                       ras_empty_o,
  output logic                       ras_ovf_o,
  output logic                       ras_udf_o
);

  logic [XLEN-1:0] w_pc_seq;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] w_ras_top;
  logic            w_push;
  logic            w_pop;
  logic            w_ovf;
  logic            w_udf;
  func3_e          w_f3;

  assign w_pc_seq = pc_q + XLEN'(PC_STEP);
  assign w_target = target_i & ~XLEN'(1);
  assign w_f3     = func3_e'(func3_i);

  // Next-PC mux and stack requests; stall suppresses every state change.
  always_comb begin
    w_pc_next = w_pc_seq;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_ovf     = 1'b0;
    w_udf     = 1'b0;
    if (is_b_type_i && !stall_i) begin
      case (w_f3)
        F3_CALL: begin
          w_push    = 1'b1;
          w_ovf     = ras_full_o;
          w_pc_next = w_target;
        end
        F3_RET: begin
          if (ras_empty_o) begin
            w_udf     = 1'b1;
            w_pc_next = TRAP_PC;
          end else begin
            w_pop     = 1'b1;
            w_pc_next = w_ras_top;
          end
        end
        default: begin
          if (br_taken_i || pc_sel_i) begin
            w_pc_next = w_target;
          end
        end
      endcase
    end
  end

  // PC register and sticky error flags; a new event wins over a clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q      <= RESET_PC;
      ras_ovf_o <= 1'b0;
      ras_udf_o <= 1'b0;
    end else if (!stall_i) begin
      pc_q      <= w_pc_next;
      ras_ovf_o <= w_ovf | (ras_ovf_o & ~err_clr_i);
      ras_udf_o <= w_udf | (ras_udf_o & ~err_clr_i);
    end
  end

  ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras_stack (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (w_push),
    .pop_i       (w_pop),
    .push_data_i (w_pc_seq),
    .top_o       (w_ras_top),
    .count_o     (ras_count_o),
    .full_o      (ras_full_o),
    .empty_o     (ras_empty_o)
  );

endmodule

// File: doc/pc_ras_unit.md
PC_RAS_UNIT -- requirements
Module: pc_ras_unit

Interface
REQ-001 SHALL have parameter XLEN, default 19, PC/address width.
REQ-002 SHALL have parameter RAS_DEPTH, default 8, return-address-stack entries (power of two, >=2).
REQ-003 SHALL have parameter RESET_PC, default 19'h00100, PC value loaded on reset.
REQ-004 SHALL have parameter TRAP_PC, default 19'h00000, redirect target on RET underflow.
REQ-005 SHALL have parameter PC_STEP, default 4, sequential increment.
REQ-006 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-007 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port stall_i  input  1  hold all state this cycle.
REQ-009 SHALL have port is_b_type_i  input  1  current instruction is branch/CALL/RET.
REQ-010 SHALL have port func3_i  input  3  branch/CALL/RET selector.
REQ-011 SHALL have port br_taken_i  input  1  branch condition true.
REQ-012 SHALL have port pc_sel_i  input  1  forced redirect, ORed with br_taken_i.
REQ-013 SHALL have port target_i  input  XLEN  branch/CALL target.
REQ-014 SHALL have port err_clr_i  input  1  clear sticky error flags.
REQ-015 SHALL have port pc_q  output  XLEN  current PC.
REQ-016 SHALL have port ras_count_o  output  $clog2(RAS_DEPTH)+1  valid entries.
REQ-017 SHALL have ports ras_full_o, ras_empty_o  output  1 each  count==RAS_DEPTH / count==0.
REQ-018 SHALL have ports ras_ovf_o, ras_udf_o  output  1 each  sticky overflow / underflow flags.

Function
REQ-019 SHALL default next PC to pc_q+PC_STEP, modulo 2^XLEN.
REQ-020 SHALL, with is_b_type_i and func3 in {000,001,100,101,110,111} and (br_taken_i|pc_sel_i), load {target_i[XLEN-1:1],1'b0}; otherwise sequential.
REQ-021 SHALL treat func3=010 as CALL: push pc_q+PC_STEP, load {target_i[XLEN-1:1],1'b0}.
REQ-022 SHALL treat func3=011 as RET: pop top entry, load it as next PC.
REQ-023 SHALL, on CALL while full, overwrite the oldest entry (circular), keep count at RAS_DEPTH, set ras_ovf_o.
REQ-024 SHALL, on RET while empty, load TRAP_PC, leave count at 0, set ras_udf_o.
REQ-025 SHALL hold pc_q, stack, count and flags unchanged while stall_i=1, regardless of other inputs.
REQ-026 SHALL ignore func3_i, br_taken_i and pc_sel_i when is_b_type_i=0.
REQ-027 SHALL clear ras_ovf_o/ras_udf_o on err_clr_i unless a new ovf/udf occurs that same cycle (set wins).
REQ-028 SHALL update pc_q one cycle after inputs are sampled; all outputs registered or derived from registers only.
REQ-029 SHALL make a pushed value visible to a RET on the immediately following cycle.

Reset
REQ-030 SHALL, on reset_n low, asynchronously set pc_q=RESET_PC, count=0, stack pointer=0, ras_ovf_o=ras_udf_o=0, ras_empty_o=1, ras_full_o=0.
REQ-031 SHALL not reset stack data storage; entries are unreadable until pushed.
REQ-032 SHALL, on reset mid-sequence, discard all pending return addresses.

Structure
REQ-033 SHALL place func3 encodings (BEQ..BGEU, CALL=010, RET=011) as a typedef enum in shared package cpu_pkg.
REQ-034 SHALL implement the stack as sub-module ras_stack (push, pop, top, count, full, empty) parametrised by XLEN and RAS_DEPTH.
REQ-035 SHALL keep the next-PC mux in pc_ras_unit; no other sub-modules.

Verification
REQ-036 Reset release, no b-type for 3 cycles -> pc_q 0x100, 0x104, 0x108, 0x10C.
REQ-037 At pc_q=0x200, CALL target 0x0403 -> pc_q=0x402, count=1; then RET -> pc_q=0x204, count=0, ras_empty_o=1.
REQ-038 Nine CALLs with RAS_DEPTH=8 -> ras_full_o=1, ras_ovf_o=1, count=8; eight RETs return most recent eight addresses in LIFO order; ninth RET -> pc_q=TRAP_PC, ras_udf_o=1.
REQ-039 Branch func3=000, br_taken_i=0, pc_sel_i=1, target 0x1235 -> pc_q=0x1234; br_taken_i=0, pc_sel_i=0 -> sequential.
REQ-040 stall_i=1 asserted with CALL present for 2 cycles -> pc_q and count unchanged; release -> CALL executes once.
REQ-041 err_clr_i with flags set -> both clear next cycle; err_clr_i coincident with RET on empty -> ras_udf_o stays 1.
